// File: rtl/regincr_pipe.sv
// regincr_pipe: valid/ready pipeline of NSTAGES register+increment stages with a combinational ready chain.
// Define REGINCR_PIPE_SAT_EN for a saturating increment; otherwise the increment wraps.
module regincr_pipe #(
  parameter int NBITS = 8,
  parameter int NSTAGES = 2,
  parameter logic [NBITS-1:0] INCR = NBITS'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg
);
  function automatic logic [NBITS-1:0] f(input logic [NBITS-1:0] x);
`ifdef REGINCR_PIPE_SAT_EN
    logic [NBITS:0] s;
    s = {1'b0, x} + {1'b0, INCR};
    return s[NBITS] ? '1 : s[NBITS-1:0];
`else
    return x + INCR;
`endif
  endfunction
  logic [NSTAGES-1:0] val, src_val;
  logic [NSTAGES:0] go;
  logic [NBITS-1:0] data [NSTAGES];
  logic [NBITS-1:0] src [NSTAGES];
  // go[i]: stage i can take a new value this cycle; go[NSTAGES] is the sink
  always_comb begin
    go = '0;
    go[NSTAGES] = out_rdy;
    for (int i = NSTAGES - 1; i >= 0; i--) go[i] = !val[i] || go[i+1];
  end
  always_comb begin
    src_val = '0;
    src_val[0] = in_val;
    src[0] = in_msg;
    for (int i = 1; i < NSTAGES; i++) begin
      src_val[i] = val[i-1];
      src[i] = f(data[i-1]);
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      val <= '0;
      for (int i = 0; i < NSTAGES; i++) data[i] <= '0;
    end else
      for (int i = 0; i < NSTAGES; i++)
        if (go[i]) begin
          val[i] <= src_val[i];
          if (src_val[i]) data[i] <= src[i];
        end
  assign in_rdy = reset && go[0];
  assign out_val = val[NSTAGES-1];
  assign out_msg = f(data[NSTAGES-1]);
endmodule

// File: tb/tb_regincr_pipe.sv
// tb_regincr_pipe: scoreboard bench for a default regincr_pipe and a 16-bit/4-stage/+3 instance.
module tb_regincr_pipe;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic a_in_val = 0, a_in_rdy, a_out_val, a_out_rdy = 1;
  logic [7:0] a_in_msg = 0, a_out_msg;
  logic b_in_val = 0, b_in_rdy, b_out_val, b_out_rdy = 1;
  logic [15:0] b_in_msg = 0, b_out_msg;
  logic [7:0] qa [$];
  logic [15:0] qb [$];
  int errs = 0, checks = 0, a_wait = 0;
`ifdef REGINCR_PIPE_SAT_EN
  localparam logic [7:0] E_FF = 8'hFF, E_FE = 8'hFF;
`else
  localparam logic [7:0] E_FF = 8'h01, E_FE = 8'h00;
`endif
  regincr_pipe dut_a (.clk(clk), .reset(reset), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg));
  regincr_pipe #(.NBITS(16), .NSTAGES(4), .INCR(16'd3)) dut_b (.clk(clk), .reset(reset), .in_val(b_in_val),
    .in_rdy(b_in_rdy), .in_msg(b_in_msg), .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] model_b(input logic [15:0] m);
    logic [16:0] s;
    s = {1'b0, m} + 17'd12;
`ifdef REGINCR_PIPE_SAT_EN
    return s[16] ? 16'hFFFF : s[15:0];
`else
    return s[15:0];
`endif
  endfunction
  always @(negedge clk)
    if (!reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_val && a_out_rdy) begin
        if (qa.size() == 0) begin
          checks++; errs++;
          $display("FAIL a_unexpected_out: got %h with empty scoreboard", a_out_msg);
        end else chk("a_out", {24'b0, a_out_msg}, {24'b0, qa.pop_front()});
      end
      if (b_out_val && b_out_rdy) begin
        if (qb.size() == 0) begin
          checks++; errs++;
          $display("FAIL b_unexpected_out: got %h with empty scoreboard", b_out_msg);
        end else chk("b_out", {16'b0, b_out_msg}, {16'b0, qb.pop_front()});
      end
    end
  task automatic send_a(input logic [7:0] m, input logic [7:0] e);
    int t;
    logic ok;
    a_in_val = 1; a_in_msg = m; ok = 0; t = 0;
    while (!ok && t < 40) begin
      @(negedge clk);
      if (a_in_rdy) begin
        ok = 1;
        qa.push_back(e);
      end else t++;
    end
    a_wait = t;
    chk("a_accept", {31'b0, ok}, 1);
    @(posedge clk); #1;
    a_in_val = 0;
  endtask
  task automatic send_b(input logic [15:0] m, input logic [15:0] e);
    int t;
    logic ok;
    b_in_val = 1; b_in_msg = m; ok = 0; t = 0;
    while (!ok && t < 40) begin
      @(negedge clk);
      if (b_in_rdy) begin
        ok = 1;
        qb.push_back(e);
      end else t++;
    end
    chk("b_accept", {31'b0, ok}, 1);
    @(posedge clk); #1;
    b_in_val = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    a_in_val = 1; a_in_msg = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", {31'b0, a_in_rdy}, 0);
    chk("rst_out_val", {31'b0, a_out_val}, 0);
    chk("rst_out_msg", {24'b0, a_out_msg}, 32'h01);
    chk("rst_b_out_msg", {16'b0, b_out_msg}, 32'h0003);
    @(posedge clk); #1;
    reset = 1; a_in_val = 0;
    @(negedge clk);
    chk("post_rst_in_rdy", {31'b0, a_in_rdy}, 1);
    chk("post_rst_out_val", {31'b0, a_out_val}, 0);
    @(posedge clk); #1;
    send_a(8'h00, 8'h02);
    @(negedge clk);
    chk("lat_early_out_val", {31'b0, a_out_val}, 0);
    @(negedge clk);
    chk("lat_out_val", {31'b0, a_out_val}, 1);
    chk("lat_out_msg", {24'b0, a_out_msg}, 32'h02);
    @(posedge clk); #1;
    send_a(8'h13, 8'h15);
    send_a(8'h27, 8'h29);
    chk("b2b_wait_27", a_wait, 0);
    send_a(8'h40, 8'h42);
    chk("b2b_wait_40", a_wait, 0);
    send_a(8'hFF, E_FF);
    send_a(8'hFE, E_FE);
    repeat (4) @(posedge clk); #1;
    a_out_rdy = 0;
    send_a(8'h10, 8'h12);
    send_a(8'h11, 8'h13);
    a_in_val = 1; a_in_msg = 8'h12;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_rdy", {31'b0, a_in_rdy}, 0);
      chk("stall_out_val", {31'b0, a_out_val}, 1);
      chk("stall_out_msg", {24'b0, a_out_msg}, 32'h12);
    end
    @(posedge clk); #1;
    a_out_rdy = 1;
    send_a(8'h12, 8'h14);
    repeat (4) @(posedge clk); #1;
    a_out_rdy = 0;
    send_a(8'h50, 8'h52);
    send_a(8'h51, 8'h53);
    reset = 0; a_in_val = 1; a_in_msg = 8'h77;
    @(negedge clk);
    chk("rst_edge_in_rdy", {31'b0, a_in_rdy}, 0);
    @(posedge clk); #1;
    reset = 1; a_in_val = 0;
    @(negedge clk);
    chk("flush_out_val", {31'b0, a_out_val}, 0);
    @(posedge clk); #1;
    a_out_rdy = 1;
    repeat (5) @(posedge clk); #1;
    send_a(8'h40, 8'h42);
    repeat (4) @(posedge clk); #1;
    chk("a_drained", qa.size(), 0);
    send_b(16'hFFF0, 16'hFFFC);
    repeat (3) begin
      @(negedge clk);
      chk("b_lat_early", {31'b0, b_out_val}, 0);
    end
    @(negedge clk);
    chk("b_lat_out_val", {31'b0, b_out_val}, 1);
    chk("b_lat_out_msg", {16'b0, b_out_msg}, 32'hFFFC);
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      b_in_val = 1'($urandom_range(0, 1));
      b_in_msg = 16'($urandom);
      b_out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b_in_val && b_in_rdy) qb.push_back(model_b(b_in_msg));
      @(posedge clk); #1;
    end
    b_in_val = 0; b_out_rdy = 1;
    repeat (10) @(posedge clk); #1;
    chk("b_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regincr_pipe.md
REGINCR_PIPE -- requirements
Module: regincr_pipe

Interface
REQ-001 Parameter NBITS, default 8, data width in bits; SHALL be >= 1.
REQ-002 Parameter NSTAGES, default 2, number of register+increment stages; SHALL be >= 1.
REQ-003 Parameter INCR, default 1, unsigned per-stage increment, NBITS wide; SHALL be < 2^NBITS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
REQ-006 in_val  input  1  upstream data valid.
REQ-007 in_rdy  output  1  block can accept in_msg this cycle.
REQ-008 in_msg  input  NBITS  input operand.
REQ-009 out_val  output  1  out_msg valid.
REQ-010 out_rdy  input  1  downstream can accept out_msg this cycle.
REQ-011 out_msg  output  NBITS  result.

Function
REQ-012 Stage i SHALL hold a valid bit val[i] and data register data[i]; stage output SHALL be f(data[i]), where f(x) = x + INCR.
REQ-013 Stage 0 loads in_msg; stage i>0 loads f(data[i-1]); out_msg = f(data[NSTAGES-1]), out_val = val[NSTAGES-1].
REQ-014 Transfer occurs on a side when its val and rdy are both 1 at a rising edge; no other condition moves data.
REQ-015 Stage i SHALL be ready when val[i]=0 or the next stage/output accepts this cycle; in_rdy = ready of stage 0.
REQ-016 Ready chain from out_rdy to in_rdy SHALL be combinational, so a full pipeline with out_rdy=1 and in_val=1 accepts and emits in the same cycle.
REQ-017 Latency: a message accepted at edge k SHALL present out_val=1 after edge k+NSTAGES-1 (i.e. visible during cycle k+NSTAGES) if no stall occurs.
REQ-018 Throughput: one message per cycle with out_rdy held 1.
REQ-019 End-to-end result: out_msg = in_msg + NSTAGES*INCR mod 2^NBITS (wrap mode).
REQ-020 Messages SHALL leave in acceptance order; none dropped or duplicated.
REQ-021 Bubbles SHALL collapse: an empty stage accepts even if downstream is stalled.
REQ-022 Full condition: all val[i]=1 and out_rdy=0 -> in_rdy=0, all registers hold.
REQ-023 out_msg/out_val SHALL remain stable while out_val=1 and out_rdy=0.
REQ-024 Data registers SHALL not load when the stage does not accept (no change on invalid data).

Reset
REQ-025 With reset=0 at a rising edge, all val[i] SHALL clear to 0; data registers SHALL clear to 0.
REQ-026 During and after reset: out_val=0, out_msg=INCR (f(0)), in_rdy=1 once reset=1 (in_rdy forced 0 while reset=0).
REQ-027 Reset mid-operation SHALL discard all in-flight messages; no input is accepted at a reset edge.

Configuration
REQ-028 Macro REGINCR_PIPE_SAT_EN: when defined, f(x) SHALL saturate: f(x) = 2^NBITS-1 if x + INCR >= 2^NBITS, else x + INCR.
REQ-029 Without REGINCR_PIPE_SAT_EN, f(x) SHALL wrap modulo 2^NBITS; handshake and latency identical in both builds.

Verification (NBITS=8, NSTAGES=2, INCR=1 unless noted)
REQ-030 Reset held 2 cycles, released; in_val=1, in_msg=0x00, out_rdy=1 -> out_val=1, out_msg=0x02 two cycles after acceptance.
REQ-031 Back-to-back in_msg 0x13,0x27,0x40 with out_rdy=1 -> out_msg 0x15,0x29,0x42 on consecutive cycles, in_rdy constant 1.
REQ-032 in_msg=0xFF -> out_msg=0x01 in wrap build; 0xFF with REGINCR_PIPE_SAT_EN; also in_msg=0xFE -> 0x00 wrap / 0xFF saturated.
REQ-033 out_rdy=0, send 0x10,0x11,0x12 -> two accepted, in_rdy=0 with 0x12 pending, out_msg stable 0x12; raise out_rdy -> outputs 0x12,0x13,0x14 in order.
REQ-034 Load two messages, assert reset=0 for 1 cycle -> out_val=0 next cycle, no stale message ever emitted afterward.
REQ-035 NSTAGES=4, INCR=3, NBITS=16, in_msg=0xFFF0 -> out_msg=0xFFFC after 4 cycles; random in_val/out_rdy run checked against scoreboard model.
